// File: rtl/exception_unit_if.sv
// Exception unit port bundle: requests, PC paths, vector fetch and PC load.
// Latency: none. The bundle holds no logic.
// Backpressure: the vector fetch waits on mem_ready; there is no other stall path.
interface exception_unit_if #(
    parameter int WIDTH  = 32,
    parameter int NCAUSE = 3,
    parameter int CW     = $clog2(NCAUSE + 1)
);
    logic [NCAUSE-1:0] exc_req;
    logic [NCAUSE-1:0] exc_mask;
    logic [WIDTH-1:0]  pc_in;
    logic [WIDTH-1:0]  alu_out;
    logic              rfe;
    logic [7:0]        mem_rdata;
    logic              mem_ready;
    logic [WIDTH-1:0]  addr_out;
    logic              mem_rd;
    logic [WIDTH-1:0]  epc;
    logic [CW-1:0]     cause;
    logic [NCAUSE-1:0] pending;
    logic              busy;
    logic              pc_load;
    logic [WIDTH-1:0]  pc_target;

    // The exception unit itself: consumes requests and memory data, drives the address and PC load.
    modport slave (
        input  exc_req, exc_mask, pc_in, alu_out, rfe, mem_rdata, mem_ready,
        output addr_out, mem_rd, epc, cause, pending, busy, pc_load, pc_target
    );

    // The surrounding core or bench.
    modport master (
        output exc_req, exc_mask, pc_in, alu_out, rfe, mem_rdata, mem_ready,
        input  addr_out, mem_rd, epc, cause, pending, busy, pc_load, pc_target
    );
endinterface

// File: rtl/exception_unit.sv
// Prioritised exception entry: saves the EPC, fetches a vector byte and loads the PC; also handles rfe.
// Latency: 1 cycle from a sampled request to FETCH. PC load comes 1 cycle after mem_ready is seen.
// Backpressure: FETCH waits without limit on mem_ready. Requests that arrive meanwhile stay sticky in pending.
module exception_unit #(
    parameter int WIDTH    = 32,
    parameter int NCAUSE   = 3,
    parameter int VEC_BASE = 253
) (
    input  logic              clk,
    input  logic              reset,
    exception_unit_if.slave   bus
);
    localparam int CW = $clog2(NCAUSE + 1);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  epc_q, epc_d;
    logic [CW-1:0]     cause_q, cause_d;
    logic [NCAUSE-1:0] pend_q, pend_d;
    logic [7:0]        byte_q, byte_d;
    logic              rfe_q, rfe_d;

    logic [NCAUSE-1:0] eff;
    logic [NCAUSE-1:0] win_onehot;
    logic [CW-1:0]     win_code;
    logic [WIDTH-1:0]  vec_addr;

    // Effective requests: sticky pending plus this cycle's unmasked requests.
    // The mask gates only new requests, so bits already pending survive a later mask change.
    assign eff      = pend_q | (bus.exc_req & ~bus.exc_mask);
    assign vec_addr = WIDTH'(VEC_BASE) + WIDTH'(cause_q) - WIDTH'(1);

    // Priority pick: the lowest set bit wins. The loop runs downward so the lowest index is assigned last.
    always_comb begin
        win_code   = '0;
        win_onehot = '0;
        for (int i = NCAUSE - 1; i >= 0; i--) begin
            if (eff[i]) begin
                win_code       = CW'(i + 1);
                win_onehot     = '0;
                win_onehot[i]  = 1'b1;
            end
        end
    end

    // Next-state, next-value and output logic for the IDLE/FETCH/LOAD sequence.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        pend_d  = pend_q;
        byte_d  = byte_q;
        rfe_d   = 1'b0;

        bus.busy      = (state_q != IDLE);
        bus.mem_rd    = (state_q == FETCH);
        bus.addr_out  = (state_q == FETCH) ? vec_addr : bus.alu_out;
        bus.pc_load   = (state_q == LOAD) | rfe_q;
        bus.pc_target = (state_q == LOAD) ? WIDTH'(byte_q) : epc_q;
        bus.epc       = epc_q;
        bus.cause     = cause_q;
        bus.pending   = pend_q;

        case (state_q)
            IDLE: begin
                if (eff != '0) begin
                    // An exception in the same cycle overrides rfe. pc_in is already incremented, so step back one word.
                    epc_d   = bus.pc_in - WIDTH'(4);
                    cause_d = win_code;
                    pend_d  = eff & ~win_onehot;
                    state_d = FETCH;
                end else begin
                    rfe_d   = bus.rfe;
                end
            end
            FETCH: begin
                pend_d = eff;
                if (bus.mem_ready) begin
                    byte_d  = bus.mem_rdata;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pend_d  = eff;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and context registers. Reset drops any in-flight sequence along with the pending requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            pend_q  <= '0;
            byte_q  <= '0;
            rfe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            pend_q  <= pend_d;
            byte_q  <= byte_d;
            rfe_q   <= rfe_d;
        end
    end
endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath/address width.
REQ-002 SHALL provide parameter NCAUSE, default 3, number of exception sources; cause code i+1 for request bit i.
REQ-003 SHALL provide parameter VEC_BASE, default 253, address of the vector byte for cause code 1; cause code c uses VEC_BASE+c-1.
REQ-004 SHALL define CW = clog2(NCAUSE+1), width of the cause code.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 exc_req  in  NCAUSE  exception requests, sampled every cycle; bit 0 = invalid opcode, 1 = overflow, 2 = divide-by-zero.
REQ-008 exc_mask  in  NCAUSE  1 = corresponding request ignored.
REQ-009 pc_in  in  WIDTH  already-incremented PC of the faulting instruction.
REQ-010 alu_out  in  WIDTH  normal memory address path.
REQ-011 rfe  in  1  return-from-exception strobe.
REQ-012 mem_rdata  in  8  byte read from memory.
REQ-013 mem_ready  in  1  memory read data valid.
REQ-014 addr_out  out  WIDTH  memory address (alu_out or vector address).
REQ-015 mem_rd  out  1  vector read request.
REQ-016 epc  out  WIDTH  saved exception PC.
REQ-017 cause  out  CW  code of the last exception taken; 0 = none.
REQ-018 pending  out  NCAUSE  sticky requests not yet serviced.
REQ-019 busy  out  1  high when state is not IDLE.
REQ-020 pc_load  out  1  one-cycle PC write strobe.
REQ-021 pc_target  out  WIDTH  value the PC is to be loaded with.

Function
REQ-022 SHALL implement states IDLE, FETCH and LOAD; busy = (state != IDLE).
REQ-023 Effective request SHALL be eff = pending | (exc_req & ~exc_mask); lowest set bit index has highest priority.
REQ-024 In IDLE with eff != 0, the next edge SHALL set epc = pc_in - 4 (modulo 2^WIDTH), set cause = winning index + 1, clear the winner from pending, set the other eff bits into pending, and enter FETCH.
REQ-025 In FETCH, mem_rd SHALL be 1 and addr_out SHALL be VEC_BASE + cause - 1, zero-extended to WIDTH; in all other states addr_out SHALL equal alu_out combinationally.
REQ-026 FETCH SHALL hold until mem_ready = 1, then capture mem_rdata and enter LOAD; wait length is unbounded.
REQ-027 LOAD SHALL last exactly one cycle with pc_load = 1 and pc_target = the captured byte zero-extended, then return to IDLE.
REQ-028 Requests arriving in FETCH or LOAD SHALL be OR-ed into pending (unmasked bits only) and serviced from IDLE in priority order, one per exception sequence.
REQ-029 Mask SHALL apply only at sampling; bits already in pending are not cleared by a later mask change.
REQ-030 rfe in IDLE with eff = 0 SHALL produce pc_load = 1 and pc_target = epc on the following cycle for one cycle; epc and cause SHALL remain unchanged.
REQ-031 rfe with eff != 0 in IDLE SHALL be dropped, with the exception taken; rfe in FETCH or LOAD SHALL be ignored.
REQ-032 pc_load SHALL be 0 in every cycle not covered by REQ-027 or REQ-030.
REQ-033 Exception entry latency SHALL be 1 cycle from sampled request to FETCH; pc_load SHALL assert on the cycle after mem_ready is sampled high.

Reset
REQ-034 On reset = 0, asynchronously: state = IDLE, epc = 0, cause = 0, pending = 0, captured byte = 0, pc_load = 0, mem_rd = 0.
REQ-035 Reset asserted mid-sequence SHALL abandon the sequence and discard pending requests; the first edge after release SHALL begin in IDLE.

Verification
REQ-036 Overflow only (exc_req = 3'b010), pc_in = 0x104 -> next cycle epc = 0x100, cause = 2, addr_out = 254, mem_rd = 1; mem_ready with mem_rdata = 0x40 -> next cycle pc_load = 1, pc_target = 0x40.
REQ-037 exc_req = 3'b111 in one cycle, mask = 0 -> cause 1 (addr 253) serviced first with pending = 3'b110; then cause 2, then cause 3, each in its own sequence.
REQ-038 exc_req = 3'b100 with exc_mask = 3'b100 -> no state change, pending = 0, addr_out follows alu_out.
REQ-039 After an exception with epc = 0x100, rfe in IDLE -> next cycle pc_load = 1, pc_target = 0x100; same rfe together with exc_req = 3'b001 -> exception taken and no rfe load.
REQ-040 Reset dropped during FETCH with pending = 3'b100 -> immediate IDLE, mem_rd = 0, pending = 0, cause = 0, epc = 0.
REQ-041 Hold mem_ready low 10 cycles in FETCH while asserting exc_req = 3'b001 -> state stays FETCH, pending = 3'b001, addr_out constant.
